// File: rtl/cluster_axi2tcdm_bridge_pkg.sv
// Shared encodings, FSM states and the burst address helper for the AXI-to-TCDM bridge.
package cluster_axi2tcdm_bridge_pkg;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_WRESP} state_e;

  // Next beat address; the reserved burst encoding behaves as INCR.
  function automatic logic [63:0] burst_next_addr(input logic [63:0] addr, input logic [7:0] len,
                                                  input logic [2:0] size, input logic [1:0] burst);
    logic [63:0] step, wmask, nxt;
    step  = 64'd1 << size;
    wmask = ((64'(len) + 64'd1) << size) - 64'd1;
    case (burst)
      BURST_FIXED: nxt = addr;
      BURST_WRAP:  nxt = (addr & ~wmask) | ((addr + step) & wmask);
      default:     nxt = addr + step;
    endcase
    return nxt;
  endfunction
endpackage

// File: rtl/cluster_axi2tcdm_rsp_fifo.sv
// Two-entry read-response buffer; push and pop may coincide whenever an entry is available.
module cluster_axi2tcdm_rsp_fifo #(
  parameter int W = 65
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [1:0]   cnt_o
);
  logic [1:0][W-1:0] mem_q;
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        cnt_q;
  logic              push_ok, pop_ok;

  assign empty_o = (cnt_q == 2'd0);
  assign full_o  = (cnt_q == 2'd2);
  assign cnt_o   = cnt_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end
endmodule

// File: rtl/cluster_axi2tcdm_bridge.sv
// AXI4 burst slave that serialises one transaction at a time into single-word TCDM requests,
// alternating reads and writes when both address channels contend.
module cluster_axi2tcdm_bridge import cluster_axi2tcdm_bridge_pkg::*; #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 6,
  parameter int AXI_USER_WIDTH = 6,
  parameter int TCDM_SIZE      = 65536
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        aw_valid_i,
  output logic                        aw_ready_o,
  input  logic [AXI_ID_WIDTH-1:0]     aw_id_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   aw_addr_i,
  input  logic [7:0]                  aw_len_i,
  input  logic [2:0]                  aw_size_i,
  input  logic [1:0]                  aw_burst_i,
  input  logic                        w_valid_i,
  output logic                        w_ready_o,
  input  logic [AXI_DATA_WIDTH-1:0]   w_data_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] w_strb_i,
  input  logic                        w_last_i,
  output logic                        b_valid_o,
  input  logic                        b_ready_i,
  output logic [AXI_ID_WIDTH-1:0]     b_id_o,
  output logic [1:0]                  b_resp_o,
  input  logic                        ar_valid_i,
  output logic                        ar_ready_o,
  input  logic [AXI_ID_WIDTH-1:0]     ar_id_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   ar_addr_i,
  input  logic [7:0]                  ar_len_i,
  input  logic [2:0]                  ar_size_i,
  input  logic [1:0]                  ar_burst_i,
  output logic                        r_valid_o,
  input  logic                        r_ready_i,
  output logic [AXI_ID_WIDTH-1:0]     r_id_o,
  output logic [AXI_DATA_WIDTH-1:0]   r_data_o,
  output logic [1:0]                  r_resp_o,
  output logic                        r_last_o,
  output logic [AXI_USER_WIDTH-1:0]   r_user_o,
  output logic                        tcdm_req_o,
  input  logic                        tcdm_gnt_i,
  output logic [AXI_ADDR_WIDTH-1:0]   tcdm_add_o,
  output logic                        tcdm_wen_o,
  output logic [AXI_DATA_WIDTH/8-1:0] tcdm_be_o,
  output logic [AXI_DATA_WIDTH-1:0]   tcdm_wdata_o,
  input  logic                        tcdm_r_valid_i,
  input  logic [AXI_DATA_WIDTH-1:0]   tcdm_r_rdata_i
);
  localparam int BE_W = AXI_DATA_WIDTH / 8;
  localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_MASK =
    AXI_ADDR_WIDTH'(TCDM_SIZE - 1) & ~AXI_ADDR_WIDTH'(BE_W - 1);

  typedef struct packed {
    logic [AXI_ID_WIDTH-1:0]   id;
    logic [AXI_ADDR_WIDTH-1:0] addr;
    logic [7:0]                len;
    logic [2:0]                size;
    logic [1:0]                burst;
  } txn_t;

  state_e                  state_q, state_d;
  txn_t                    txn_q, txn_d;
  logic [8:0]              issued_q, issued_d, rcvd_q, rcvd_d;
  logic                    prio_rd_q, prio_rd_d;
  logic                    inflight_q;
  logic                    ar_hs, aw_hs, rd_can_issue, rd_gnt, wr_gnt, wr_last;
  logic                    fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [1:0]              fifo_cnt;
  logic [2:0]              fifo_free;
  logic [AXI_DATA_WIDTH:0] fifo_rdata;
  logic [63:0]             addr_nxt;
  logic                    unused_w_last;

  assign unused_w_last = w_last_i;
  assign ar_hs   = ar_valid_i && ar_ready_o;
  assign aw_hs   = aw_valid_i && aw_ready_o;
  assign wr_gnt  = (state_q == ST_WRITE) && w_valid_i && tcdm_gnt_i;
  assign wr_last = (issued_q == {1'b0, txn_q.len});
  assign rd_gnt  = rd_can_issue && tcdm_gnt_i;
  assign addr_nxt = burst_next_addr(64'(txn_q.addr), txn_q.len, txn_q.size, txn_q.burst);

  // Counting the same-cycle pop as free space keeps reads streaming at one beat per cycle.
  assign fifo_pop     = !fifo_empty && r_ready_i;
  assign fifo_free    = 3'd2 - {1'b0, fifo_cnt} + {2'b0, fifo_pop};
  assign rd_can_issue = (state_q == ST_READ) && (issued_q <= {1'b0, txn_q.len}) &&
                        (fifo_free > {2'b0, inflight_q});
  assign fifo_push    = inflight_q && tcdm_r_valid_i;

  cluster_axi2tcdm_rsp_fifo #(.W(AXI_DATA_WIDTH + 1)) i_rsp_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .data_i  ({tcdm_r_rdata_i, rcvd_q == {1'b0, txn_q.len}}),
    .pop_i   (fifo_pop),
    .data_o  (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .cnt_o   (fifo_cnt)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (ar_hs) state_d = ST_READ; else if (aw_hs) state_d = ST_WRITE;
      ST_READ:  if (fifo_pop && fifo_rdata[0]) state_d = ST_IDLE;
      ST_WRITE: if (wr_gnt && wr_last) state_d = ST_WRESP;
      ST_WRESP: if (b_ready_i) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ar_ready_o   = 1'b0;
    aw_ready_o   = 1'b0;
    w_ready_o    = 1'b0;
    b_valid_o    = 1'b0;
    tcdm_req_o   = 1'b0;
    tcdm_wen_o   = 1'b0;
    tcdm_be_o    = '0;
    tcdm_wdata_o = '0;
    case (state_q)
      ST_IDLE: begin
        ar_ready_o = ar_valid_i && (!aw_valid_i || prio_rd_q);
        aw_ready_o = aw_valid_i && (!ar_valid_i || !prio_rd_q);
      end
      ST_READ: begin
        tcdm_req_o = rd_can_issue;
        tcdm_wen_o = 1'b1;
        tcdm_be_o  = '1;
      end
      ST_WRITE: begin
        tcdm_req_o   = w_valid_i;
        w_ready_o    = tcdm_gnt_i;
        tcdm_be_o    = w_strb_i;
        tcdm_wdata_o = w_data_i;
      end
      ST_WRESP: b_valid_o = 1'b1;
      default: ;
    endcase
  end

  assign tcdm_add_o = txn_q.addr & ADDR_MASK;
  assign b_id_o     = txn_q.id;
  assign b_resp_o   = RESP_OKAY;
  assign r_valid_o  = !fifo_empty;
  assign r_id_o     = txn_q.id;
  assign r_data_o   = fifo_rdata[AXI_DATA_WIDTH:1];
  assign r_last_o   = fifo_rdata[0];
  assign r_resp_o   = RESP_OKAY;
  assign r_user_o   = '0;

  // Priority only flips when both channels contend, so a lone request never steals the turn.
  always_comb begin
    txn_d     = txn_q;
    issued_d  = issued_q;
    rcvd_d    = rcvd_q;
    prio_rd_d = prio_rd_q;
    if (ar_hs) begin
      txn_d.id    = ar_id_i;
      txn_d.addr  = ar_addr_i;
      txn_d.len   = ar_len_i;
      txn_d.size  = ar_size_i;
      txn_d.burst = ar_burst_i;
      issued_d    = '0;
      rcvd_d      = '0;
    end else if (aw_hs) begin
      txn_d.id    = aw_id_i;
      txn_d.addr  = aw_addr_i;
      txn_d.len   = aw_len_i;
      txn_d.size  = aw_size_i;
      txn_d.burst = aw_burst_i;
      issued_d    = '0;
      rcvd_d      = '0;
    end
    if (state_q == ST_IDLE && ar_valid_i && aw_valid_i) prio_rd_d = !prio_rd_q;
    if (rd_gnt || wr_gnt) begin
      txn_d.addr = addr_nxt[AXI_ADDR_WIDTH-1:0];
      issued_d   = issued_q + 9'd1;
    end
    if (fifo_push) rcvd_d = rcvd_q + 9'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      txn_q      <= '0;
      issued_q   <= '0;
      rcvd_q     <= '0;
      prio_rd_q  <= 1'b1;
      inflight_q <= 1'b0;
    end else begin
      txn_q      <= txn_d;
      issued_q   <= issued_d;
      rcvd_q     <= rcvd_d;
      prio_rd_q  <= prio_rd_d;
      inflight_q <= rd_gnt;
    end
  end

  logic unused_fifo_full;
  assign unused_fifo_full = fifo_full;
endmodule

// File: tb/tb_cluster_axi2tcdm_bridge.sv
// Directed bench for the AXI-to-TCDM bridge with a one-cycle-latency TCDM responder.
module tb_cluster_axi2tcdm_bridge;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        aw_valid_i, aw_ready_o, w_valid_i, w_ready_o, w_last_i, b_valid_o, b_ready_i;
  logic [5:0]  aw_id_i, ar_id_i, b_id_o, r_id_o, r_user_o;
  logic [31:0] aw_addr_i, ar_addr_i, tcdm_add_o;
  logic [7:0]  aw_len_i, ar_len_i, w_strb_i, tcdm_be_o;
  logic [2:0]  aw_size_i, ar_size_i;
  logic [1:0]  aw_burst_i, ar_burst_i, b_resp_o, r_resp_o;
  logic [63:0] w_data_i, r_data_o, tcdm_wdata_o, tcdm_r_rdata_i;
  logic        ar_valid_i, ar_ready_o, r_valid_o, r_ready_i, r_last_o;
  logic        tcdm_req_o, tcdm_gnt_i, tcdm_wen_o, tcdm_r_valid_i;

  cluster_axi2tcdm_bridge dut (
    .clk_i(clk), .rst_i(rst),
    .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_id_i(aw_id_i), .aw_addr_i(aw_addr_i),
    .aw_len_i(aw_len_i), .aw_size_i(aw_size_i), .aw_burst_i(aw_burst_i),
    .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_data_i(w_data_i), .w_strb_i(w_strb_i),
    .w_last_i(w_last_i),
    .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_id_o(b_id_o), .b_resp_o(b_resp_o),
    .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_id_i(ar_id_i), .ar_addr_i(ar_addr_i),
    .ar_len_i(ar_len_i), .ar_size_i(ar_size_i), .ar_burst_i(ar_burst_i),
    .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_id_o(r_id_o), .r_data_o(r_data_o),
    .r_resp_o(r_resp_o), .r_last_o(r_last_o), .r_user_o(r_user_o),
    .tcdm_req_o(tcdm_req_o), .tcdm_gnt_i(tcdm_gnt_i), .tcdm_add_o(tcdm_add_o),
    .tcdm_wen_o(tcdm_wen_o), .tcdm_be_o(tcdm_be_o), .tcdm_wdata_o(tcdm_wdata_o),
    .tcdm_r_valid_i(tcdm_r_valid_i), .tcdm_r_rdata_i(tcdm_r_rdata_i)
  );

  typedef struct {logic [31:0] add; logic wen; logic [7:0] be; logic [63:0] wdata; int cyc;} treq_t;
  typedef struct {logic [5:0] id; logic [63:0] data; logic last; logic [1:0] resp; int cyc;} rbeat_t;
  typedef struct {logic [5:0] id; logic [1:0] resp;} bresp_t;

  treq_t  tq[$];
  rbeat_t rq[$];
  bresp_t bq[$];
  int     hs[$];
  int     cyc = 0;
  int     ar_cyc = 0;
  int     n_chk = 0, n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // TCDM memory model: read data is a fixed function of the word address.
  function automatic logic [63:0] exp_rd(input logic [31:0] a);
    return {~a, a};
  endfunction

  logic        rd_fire_q;
  logic [31:0] rd_add_q;
  always @(negedge clk) begin
    rd_fire_q <= tcdm_req_o && tcdm_gnt_i && tcdm_wen_o;
    rd_add_q  <= tcdm_add_o;
  end
  always @(posedge clk) begin
    tcdm_r_valid_i <= rd_fire_q;
    tcdm_r_rdata_i <= exp_rd(rd_add_q);
  end

  always @(negedge clk) if (!rst) begin
    if (tcdm_req_o && tcdm_gnt_i)
      tq.push_back('{add: tcdm_add_o, wen: tcdm_wen_o, be: tcdm_be_o, wdata: tcdm_wdata_o, cyc: cyc});
    if (r_valid_o && r_ready_i)
      rq.push_back('{id: r_id_o, data: r_data_o, last: r_last_o, resp: r_resp_o, cyc: cyc});
    if (b_valid_o && b_ready_i) bq.push_back('{id: b_id_o, resp: b_resp_o});
    if (ar_valid_i && ar_ready_o) begin hs.push_back(0); ar_cyc = cyc; end
    if (aw_valid_i && aw_ready_o) hs.push_back(1);
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic clr();
    tq.delete(); rq.delete(); bq.delete();
  endtask

  task automatic send_ar(input logic [5:0] id, input logic [31:0] a, input logic [7:0] len,
                         input logic [1:0] burst);
    bit ok = 0;
    ar_id_i = id; ar_addr_i = a; ar_len_i = len; ar_size_i = 3'd3; ar_burst_i = burst;
    ar_valid_i = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (ar_ready_o) begin ok = 1; break; end
    end
    if (!ok) chk("ar_timeout", 0, 1);
    @(posedge clk); #1;
    ar_valid_i = 1'b0;
  endtask

  task automatic send_aw(input logic [5:0] id, input logic [31:0] a, input logic [7:0] len,
                         input logic [1:0] burst);
    bit ok = 0;
    aw_id_i = id; aw_addr_i = a; aw_len_i = len; aw_size_i = 3'd3; aw_burst_i = burst;
    aw_valid_i = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (aw_ready_o) begin ok = 1; break; end
    end
    if (!ok) chk("aw_timeout", 0, 1);
    @(posedge clk); #1;
    aw_valid_i = 1'b0;
  endtask

  task automatic send_w(input int n, input logic [63:0] base, input logic [3:0][7:0] strbs);
    for (int i = 0; i < n; i++) begin
      bit ok = 0;
      w_valid_i = 1'b1; w_data_i = base + 64'(i); w_strb_i = strbs[i]; w_last_i = (i == n - 1);
      for (int t = 0; t < 100; t++) begin
        @(negedge clk);
        if (w_ready_o) begin ok = 1; break; end
      end
      if (!ok) chk("w_timeout", 0, 1);
      @(posedge clk); #1;
    end
    w_valid_i = 1'b0; w_last_i = 1'b0;
  endtask

  task automatic wait_r(input int n);
    for (int t = 0; t < 200 && rq.size() < n; t++) begin @(posedge clk); #1; end
    chk("r_count", rq.size(), n);
  endtask

  task automatic wait_b(input int n);
    for (int t = 0; t < 200 && bq.size() < n; t++) begin @(posedge clk); #1; end
    chk("b_count", bq.size(), n);
  endtask

  initial begin
    rst = 1'b1;
    aw_valid_i = 0; aw_id_i = 0; aw_addr_i = 0; aw_len_i = 0; aw_size_i = 0; aw_burst_i = 0;
    ar_valid_i = 0; ar_id_i = 0; ar_addr_i = 0; ar_len_i = 0; ar_size_i = 0; ar_burst_i = 0;
    w_valid_i = 0; w_data_i = 0; w_strb_i = 0; w_last_i = 0;
    b_ready_i = 1; r_ready_i = 1; tcdm_gnt_i = 1;
    repeat (3) @(negedge clk);
    chk("rst_r_valid", r_valid_o, 0);
    chk("rst_b_valid", b_valid_o, 0);
    chk("rst_tcdm_req", tcdm_req_o, 0);
    chk("rst_r_data", r_data_o, 0);
    chk("rst_add", tcdm_add_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // INCR read burst, aliasing into the TCDM window
    clr();
    send_ar(6'd5, 32'h1000_0100, 8'd3, 2'b01);
    wait_r(4);
    chk("rd_req_cnt", tq.size(), 4);
    for (int i = 0; i < 4 && i < tq.size(); i++) begin
      chk("rd_add", tq[i].add, 32'h100 + 32'(8 * i));
      chk("rd_wen_be", {tq[i].wen, tq[i].be}, 9'h1FF);
    end
    for (int i = 0; i < 4 && i < rq.size(); i++) begin
      chk("rd_id", rq[i].id, 6'd5);
      chk("rd_data", rq[i].data, exp_rd(32'h100 + 32'(8 * i)));
      chk("rd_last", rq[i].last, i == 3);
      chk("rd_resp", rq[i].resp, 2'b00);
    end
    if (tq.size() > 0) chk("req_latency", tq[0].cyc - ar_cyc, 1);
    if (rq.size() == 4) begin
      chk("r_latency", rq[0].cyc - ar_cyc, 3);
      chk("r_stream", rq[3].cyc - rq[0].cyc, 3);
    end

    // WRAP write burst
    clr();
    fork
      send_aw(6'd2, 32'h38, 8'd3, 2'b10);
      send_w(4, 64'hA000, {4{8'hFF}});
    join
    wait_b(1);
    chk("wr_req_cnt", tq.size(), 4);
    for (int i = 0; i < 4 && i < tq.size(); i++) begin
      chk("wr_add", tq[i].add, (i == 0) ? 32'h38 : 32'h20 + 32'(8 * (i - 1)));
      chk("wr_wen_be", {tq[i].wen, tq[i].be}, 9'h0FF);
      chk("wr_data", tq[i].wdata, 64'hA000 + 64'(i));
    end
    if (bq.size() > 0) chk("b_id_resp", {bq[0].id, bq[0].resp}, {6'd2, 2'b00});

    // Contending AR/AW pairs alternate
    clr(); hs.delete();
    fork
      send_ar(6'd1, 32'h10, 8'd0, 2'b01);
      begin fork send_aw(6'd4, 32'h18, 8'd0, 2'b01); send_w(1, 64'h11, {4{8'hFF}}); join end
    join
    wait_b(1); wait_r(1);
    clr();
    fork
      send_ar(6'd3, 32'h20, 8'd0, 2'b01);
      begin fork send_aw(6'd6, 32'h28, 8'd0, 2'b01); send_w(1, 64'h22, {4{8'hFF}}); join end
    join
    wait_b(1); wait_r(1);
    chk("arb_cnt", hs.size(), 4);
    if (hs.size() == 4) begin
      chk("arb_pair1_first", hs[0], 0);
      chk("arb_pair1_second", hs[1], 1);
      chk("arb_pair2_first", hs[2], 1);
      chk("arb_pair2_second", hs[3], 0);
    end
    if (rq.size() > 0) chk("arb_r_id", rq[0].id, 6'd3);
    if (bq.size() > 0) chk("arb_b_id", bq[0].id, 6'd6);

    // R backpressure caps outstanding reads at the FIFO depth
    clr();
    r_ready_i = 1'b0;
    send_ar(6'd9, 32'h200, 8'd7, 2'b01);
    repeat (10) begin @(posedge clk); #1; end
    chk("bp_reads", tq.size(), 2);
    chk("bp_beats", rq.size(), 0);
    r_ready_i = 1'b1;
    wait_r(8);
    chk("bp_req_cnt", tq.size(), 8);
    for (int i = 0; i < 8 && i < rq.size(); i++) begin
      chk("bp_data", rq[i].data, exp_rd(32'h200 + 32'(8 * i)));
      chk("bp_last", rq[i].last, i == 7);
    end

    // TCDM grant stall mid write burst, including a zero-strobe beat
    clr();
    fork
      send_aw(6'd3, 32'h400, 8'd2, 2'b01);
      send_w(3, 64'hBEEF_0000, {8'h00, 8'h00, 8'h0F, 8'hFF});
      begin
        for (int t = 0; t < 100 && tq.size() < 1; t++) begin @(posedge clk); #1; end
        tcdm_gnt_i = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_req", {tcdm_req_o, tcdm_wen_o, w_ready_o}, 3'b100);
          chk("stall_add", tcdm_add_o, 32'h408);
          chk("stall_wdata", tcdm_wdata_o, 64'hBEEF_0001);
          chk("stall_be", tcdm_be_o, 8'h0F);
        end
        @(posedge clk); #1;
        tcdm_gnt_i = 1'b1;
      end
    join
    wait_b(1);
    chk("stall_req_cnt", tq.size(), 3);
    if (tq.size() == 3) begin
      chk("stall_beat1", {tq[1].add, tq[1].be}, {32'h408, 8'h0F});
      chk("stall_beat2", {tq[2].add, tq[2].be}, {32'h410, 8'h00});
      chk("stall_beat2_data", tq[2].wdata, 64'hBEEF_0002);
    end
    if (bq.size() > 0) chk("stall_b_id", bq[0].id, 6'd3);

    // Reset mid read burst, then a fresh read
    clr();
    send_ar(6'd11, 32'h800, 8'd5, 2'b01);
    wait_r(2);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valids", {tcdm_req_o, r_valid_o, b_valid_o, ar_ready_o, aw_ready_o, w_ready_o}, 6'd0);
    chk("mid_rst_add", tcdm_add_o, 0);
    chk("mid_rst_rdata", {r_data_o, r_last_o}, 65'd0);
    chk("mid_rst_rid", r_id_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    clr();
    repeat (3) begin @(posedge clk); #1; end
    chk("post_rst_quiet", rq.size() + tq.size(), 0);
    send_ar(6'd7, 32'h40, 8'd1, 2'b01);
    wait_r(2);
    if (rq.size() == 2) begin
      chk("post_rst_beat0", {rq[0].id, rq[0].last}, {6'd7, 1'b0});
      chk("post_rst_beat1", {rq[1].id, rq[1].last}, {6'd7, 1'b1});
      chk("post_rst_data0", rq[0].data, exp_rd(32'h40));
      chk("post_rst_data1", rq[1].data, exp_rd(32'h48));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/cluster_axi2tcdm_bridge.md
Name: cluster_axi2tcdm_bridge

Overview:
Downstream stage of the cluster AXI crossbar's TCDM master port. Converts AXI4 bursts (ID width = crossbar output ID width) into single-beat TCDM word requests on one logarithmic-interconnect port. Serves one AXI transaction at a time, alternating fairly between reads and writes. Returns R/B responses carrying the original ID.

Parameters:
AXI_ADDR_WIDTH, 32, AXI/TCDM address width
AXI_DATA_WIDTH, 64, AXI and TCDM data width (DW); BE width = DW/8
AXI_ID_WIDTH, 6, ID width of the crossbar output
AXI_USER_WIDTH, 6, user width; not used by the bridge; R user driven to 0
TCDM_SIZE, 65536, bytes; power of two, nonzero

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
aw_valid_i/aw_ready_o, aw_id_i, aw_addr_i, aw_len_i, aw_size_i, aw_burst_i  in/out  1/1/ID/AW/8/3/2  AXI write-address channel
w_valid_i/w_ready_o, w_data_i, w_strb_i, w_last_i  in/out  1/1/DW/DW/8/1  AXI write-data channel
b_valid_o/b_ready_i, b_id_o, b_resp_o  out/in  1/1/ID/2  AXI write-response channel
ar_valid_i/ar_ready_o, ar_id_i, ar_addr_i, ar_len_i, ar_size_i, ar_burst_i  in/out  AXI read-address channel, widths as AW
r_valid_o/r_ready_i, r_id_o, r_data_o, r_resp_o, r_last_o  out/in  1/1/ID/DW/2/1  AXI read-data channel
tcdm_req_o  out  1  TCDM request
tcdm_gnt_i  in  1  TCDM grant; request retired when req && gnt
tcdm_add_o  out  AW  byte address: axi_addr & (TCDM_SIZE-1), aligned down to DW/8
tcdm_wen_o  out  1  1 = read, 0 = write
tcdm_be_o  out  DW/8  byte enables
tcdm_wdata_o  out  DW  write data
tcdm_r_valid_i  in  1  read data valid, exactly 1 cycle after a granted read
tcdm_r_rdata_i  in  DW  read data

Behaviour:
- Reset: FSM=IDLE, beat counters 0, FIFO empty, prio=read; all valid/ready/req outputs 0; data/id outputs 0.
- FSM states IDLE, READ, WRITE, WRESP.
- IDLE: ar_ready_o/aw_ready_o are asserted only in IDLE.
  - Both valid: grant the type not served last, then flip prio.
  - Single valid: grant it.
  - Handshake latches id, addr, len, size, burst, beat=0. Next state READ or WRITE.
- Address step per beat: FIXED holds the address. INCR adds 1<<size. WRAP adds 1<<size within a boundary of (len+1)<<size bytes (low bits wrap). Reserved burst 2'b11 is treated as INCR.
- READ:
  - tcdm_req_o=1, wen=1, be=all ones while beats_issued <= len and FIFO free slots > in-flight count.
  - On gnt: advance address and issued count.
  - tcdm_r_valid_i pushes {rdata, last=(beat==len)} into a 2-deep response FIFO.
  - R channel drives FIFO head: id latched, resp OKAY. Pop on r_valid && r_ready.
  - Return to IDLE after the last beat pops.
  - Minimum latency: AR handshake cycle 0 → req cycle 1 → r_valid_o cycle 3. Sustains 1 beat/cycle while r_ready_i=1.
- WRITE:
  - tcdm_req_o = w_valid_i, wen=0, be=w_strb_i, wdata=w_data_i.
  - w_ready_o = tcdm_gnt_i (combinational); a beat is consumed on req && gnt.
  - Go to WRESP after beat len is consumed; w_last_i is ignored for counting.
  - Zero strobes still issue a request.
- WRESP: b_valid_o=1, b_id_o=latched id, b_resp=OKAY; to IDLE on b_ready_i.
- No error responses are generated; out-of-range addresses alias modulo TCDM_SIZE.
- tcdm_req_o held with stable address and data until gnt (TCDM protocol).
- Reset mid-burst: immediate return to reset state; in-flight TCDM read data is dropped.

Decomposition:
- axi_pkg: burst and resp encodings.
- pulp_cluster_package: new tcdm_req_t/tcdm_rsp_t typedefs and a wrap-address helper function.
- One sub-module: cluster_axi2tcdm_rsp_fifo (2-entry, DW+1 bits, full/empty, push/pop same cycle allowed when not empty).

Test Plan:
- AR id=5, addr=0x1000_0100, len=3, size=3, INCR, gnt=1, r_ready=1 → TCDM reads 0x100, 0x108, 0x110, 0x118; 4 R beats id=5, last on 4th, OKAY; first r_valid 3 cycles after AR.
- AW id=2, addr=0x38, len=3, size=3, WRAP, strobes 0xFF → writes 0x38, 0x20, 0x28, 0x30; single B id=2 OKAY.
- AR and AW valid in same cycle, both len=0 → read served first; a second simultaneous pair → write served first.
- READ len=7 with r_ready_i=0 for 10 cycles → at most 2 TCDM reads issued, no data lost, 8 beats delivered in order once r_ready_i=1.
- WRITE with tcdm_gnt_i=0 for 3 cycles mid-burst → address, wdata and be stable; w_ready_o=0; beat retires on gnt.
- rst_i pulsed during beat 2 of len=5 read → all outputs 0 next cycle; a fresh AR after reset completes normally.
